// File: rtl/mem_stage.sv
// mem_stage: memory (M) stage of a 5-stage MIPS pipeline.
// This file holds the E/M pipeline register, the data memory, the store
// byte-enable/merge logic, the load extraction logic and the address check.
// Optional build macro MEM_DISPLAY_EN: when defined, each committed store
// prints a trace line. Without it the block prints nothing and is synthesizable.
module mem_stage #(
    parameter int          DM_WORDS = 3072,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_ins,
    input  logic [31:0] alu_res,
    input  logic [31:0] reg_rt,
    output logic [31:0] M_PC,
    output logic [31:0] M_ins,
    output logic [31:0] M_alu_res,
    output logic [31:0] mem_rdata,
    output logic        addr_err
);

    localparam int IDX_W = $clog2(DM_WORDS);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Storage
    logic [31:0]      dm_r [DM_WORDS];
    logic [31:0]      st_data_r;

    // Decode / datapath
    logic             is_load_s;
    logic             is_store_s;
    logic             sign_s;
    logic [1:0]       size_s;
    logic [1:0]       off_s;
    logic [IDX_W-1:0] idx_s;
    logic             misalign_s;
    logic             range_err_s;
    logic             addr_err_s;
    logic [31:0]      rd_word_s;
    logic [7:0]       rd_byte_s;
    logic [15:0]      rd_half_s;
    logic [31:0]      load_data_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic [31:0]      merged_s;
    logic             we_s;

    assign off_s = M_alu_res[1:0];
    assign idx_s = M_alu_res[IDX_W+1:2];

    // E/M pipeline register: flush inserts a bubble (keeping the PC), en advances, else hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            M_PC      <= PC_RESET;
            M_ins     <= 32'h0000_0000;
            M_alu_res <= 32'h0000_0000;
            st_data_r <= 32'h0000_0000;
        end else if (flush) begin
            M_PC      <= E_PC;
            M_ins     <= 32'h0000_0000;
            M_alu_res <= 32'h0000_0000;
            st_data_r <= 32'h0000_0000;
        end else if (en) begin
            M_PC      <= E_PC;
            M_ins     <= E_ins;
            M_alu_res <= alu_res;
            st_data_r <= reg_rt;
        end
    end

    // Opcode decode into load/store class, access size and signedness
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        sign_s     = 1'b0;
        size_s     = SZ_WORD;
        case (M_ins[31:26])
            OP_LW:   begin is_load_s  = 1'b1; size_s = SZ_WORD; end
            OP_LH:   begin is_load_s  = 1'b1; size_s = SZ_HALF; sign_s = 1'b1; end
            OP_LHU:  begin is_load_s  = 1'b1; size_s = SZ_HALF; end
            OP_LB:   begin is_load_s  = 1'b1; size_s = SZ_BYTE; sign_s = 1'b1; end
            OP_LBU:  begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
            OP_SW:   begin is_store_s = 1'b1; size_s = SZ_WORD; end
            OP_SH:   begin is_store_s = 1'b1; size_s = SZ_HALF; end
            OP_SB:   begin is_store_s = 1'b1; size_s = SZ_BYTE; end
            default: begin is_load_s  = 1'b0; is_store_s = 1'b0; end
        endcase
    end

    // Alignment and range check for memory instructions
    always_comb begin
        misalign_s = 1'b0;
        case (size_s)
            SZ_WORD: misalign_s = (off_s != 2'b00);
            SZ_HALF: misalign_s = off_s[0];
            SZ_BYTE: misalign_s = 1'b0;
            default: misalign_s = 1'b0;
        endcase
        range_err_s = (M_alu_res[31:2] >= 30'(DM_WORDS));
        if (is_load_s || is_store_s) begin
            addr_err_s = misalign_s || range_err_s;
        end else begin
            addr_err_s = 1'b0;
        end
    end

    assign addr_err = addr_err_s;

    // Combinational read of the addressed word; out-of-range reads never touch the array
    always_comb begin
        if (range_err_s) begin
            rd_word_s = 32'h0000_0000;
        end else begin
            rd_word_s = dm_r[idx_s];
        end
    end

    // Byte/halfword selection (little-endian) and sign/zero extension for loads
    always_comb begin
        case (off_s)
            2'd0:    rd_byte_s = rd_word_s[7:0];
            2'd1:    rd_byte_s = rd_word_s[15:8];
            2'd2:    rd_byte_s = rd_word_s[23:16];
            2'd3:    rd_byte_s = rd_word_s[31:24];
            default: rd_byte_s = 8'h00;
        endcase
        if (off_s[1]) begin
            rd_half_s = rd_word_s[31:16];
        end else begin
            rd_half_s = rd_word_s[15:0];
        end
        load_data_s = 32'h0000_0000;
        if (is_load_s && !addr_err_s) begin
            case (size_s)
                SZ_WORD: load_data_s = rd_word_s;
                SZ_HALF: load_data_s = sign_s ? {{16{rd_half_s[15]}}, rd_half_s}
                                              : {16'h0000, rd_half_s};
                SZ_BYTE: load_data_s = sign_s ? {{24{rd_byte_s[7]}}, rd_byte_s}
                                              : {24'h00_0000, rd_byte_s};
                default: load_data_s = 32'h0000_0000;
            endcase
        end else begin
            load_data_s = 32'h0000_0000;
        end
    end

    assign mem_rdata = load_data_s;

    // Store byte enables, replicated write data and the merged post-write word
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        case (size_s)
            SZ_WORD: begin be_s = 4'b1111;            wdata_s = st_data_r; end
            SZ_HALF: begin be_s = 4'b0011 << off_s;   wdata_s = {2{st_data_r[15:0]}}; end
            SZ_BYTE: begin be_s = 4'b0001 << off_s;   wdata_s = {4{st_data_r[7:0]}}; end
            default: begin be_s = 4'b0000;            wdata_s = 32'h0000_0000; end
        endcase
        for (int b = 0; b < 4; b++) begin
            merged_s[8*b +: 8] = be_s[b] ? wdata_s[8*b +: 8] : rd_word_s[8*b +: 8];
        end
        we_s = is_store_s && en && !addr_err_s;
    end

    // Data memory: cleared by reset, written with the merged word on a committed store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_r[i] <= 32'h0000_0000;
            end
        end else if (we_s) begin
            dm_r[idx_s] <= merged_s;
        end
    end

`ifdef MEM_DISPLAY_EN
    // Trace line for every committed store, showing the full post-write word
    always @(posedge clk) begin
        if (!reset && we_s) begin
            $display("%d@%h: *%h <= %h", $time, M_PC, {M_alu_res[31:2], 2'b00}, merged_s);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: hand-computed expected values.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        en;
    logic        flush;
    logic [31:0] E_PC;
    logic [31:0] E_ins;
    logic [31:0] alu_res;
    logic [31:0] reg_rt;
    logic [31:0] M_PC;
    logic [31:0] M_ins;
    logic [31:0] M_alu_res;
    logic [31:0] mem_rdata;
    logic        addr_err;

    int n_vec;
    int n_err;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] NOP = 6'b000000;

    mem_stage dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .E_PC      (E_PC),
        .E_ins     (E_ins),
        .alu_res   (alu_res),
        .reg_rt    (reg_rt),
        .M_PC      (M_PC),
        .M_ins     (M_ins),
        .M_alu_res (M_alu_res),
        .mem_rdata (mem_rdata),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Drive one E-stage instruction, clock it into M, sample 1ns after the edge
    task automatic issue(input logic [31:0] pc, input logic [5:0] op,
                         input logic [31:0] addr, input logic [31:0] rt);
        E_PC    = pc;
        E_ins   = {op, 26'h0};
        alu_res = addr;
        reg_rt  = rt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        en      = 1'b1;
        flush   = 1'b0;
        E_PC    = 32'h0;
        E_ins   = 32'h0;
        alu_res = 32'h0;
        reg_rt  = 32'h0;
        #3;
        check("rst_pc",    M_PC,      32'h0000_3000);
        check("rst_ins",   M_ins,     32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_err",   {31'h0, addr_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // word store then loads
        issue(32'h3000, SW, 32'h10, 32'h1234_5678);
        issue(32'h3004, LW, 32'h10, 32'h0);
        check("lw_10",      mem_rdata, 32'h1234_5678);
        check("lw_pc",      M_PC,      32'h0000_3004);
        check("lw_ins",     M_ins,     {LW, 26'h0});
        check("lw_alu",     M_alu_res, 32'h10);
        issue(32'h3008, LBU, 32'h13, 32'h0);
        check("lbu_13",     mem_rdata, 32'h12);
        issue(32'h300C, SW, 32'h10, 32'h8000_0000);
        issue(32'h3010, LB, 32'h13, 32'h0);
        check("lb_13_neg",  mem_rdata, 32'hFFFF_FF80);
        issue(32'h3014, LBU, 32'h13, 32'h0);
        check("lbu_13_80",  mem_rdata, 32'h80);

        // partial stores merge into the word
        issue(32'h3018, SW, 32'h20, 32'hAABB_CCDD);
        issue(32'h301C, SH, 32'h22, 32'h0000_1111);
        issue(32'h3020, SB, 32'h20, 32'h0000_0077);
        issue(32'h3024, LW, 32'h20, 32'h0);
        check("merge_20",   mem_rdata, 32'h1111_CC77);
        issue(32'h3028, LH, 32'h22, 32'h0);
        check("lh_22_pos",  mem_rdata, 32'h0000_1111);
        issue(32'h302C, LB, 32'h20, 32'h0);
        check("lb_20",      mem_rdata, 32'h0000_0077);
        issue(32'h3030, LH, 32'h20, 32'h0);
        check("lh_20_neg",  mem_rdata, 32'hFFFF_CC77);
        issue(32'h3034, SH, 32'h22, 32'h0000_8001);
        issue(32'h3038, LHU, 32'h22, 32'h0);
        check("lhu_22",     mem_rdata, 32'h0000_8001);
        issue(32'h303C, LH, 32'h22, 32'h0);
        check("lh_22_neg",  mem_rdata, 32'hFFFF_8001);
        issue(32'h3040, LBU, 32'h21, 32'h0);
        check("lbu_21",     mem_rdata, 32'h0000_00CC);

        // address errors
        issue(32'h3044, SW, 32'h21, 32'hDEAD_BEEF);
        check("sw_mis_err", {31'h0, addr_err}, 32'h1);
        issue(32'h3048, LW, 32'h20, 32'h0);
        check("sw_mis_nowr", mem_rdata, 32'h8001_CC77);
        check("lw_ok_err",  {31'h0, addr_err}, 32'h0);
        issue(32'h304C, LH, 32'h23, 32'h0);
        check("lh_mis_err", {31'h0, addr_err}, 32'h1);
        check("lh_mis_dat", mem_rdata, 32'h0);
        issue(32'h3050, SW, 32'h3000, 32'h0000_0055);
        check("sw_oor_err", {31'h0, addr_err}, 32'h1);
        issue(32'h3054, LW, 32'h3000, 32'h0);
        check("lw_oor_err", {31'h0, addr_err}, 32'h1);
        check("lw_oor_dat", mem_rdata, 32'h0);
        issue(32'h3058, LW, 32'h2FFC, 32'h0);
        check("lw_top_err", {31'h0, addr_err}, 32'h0);
        check("lw_top_dat", mem_rdata, 32'h0);
        issue(32'h305C, NOP, 32'h21, 32'h0);
        check("nop_err",    {31'h0, addr_err}, 32'h0);
        check("nop_dat",    mem_rdata, 32'h0);

        // stall with a store in M, then flush while stalled: store never commits
        issue(32'h3100, SW, 32'h30, 32'h0000_0099);
        en      = 1'b0;
        E_PC    = 32'h3104;
        E_ins   = {LW, 26'h0};
        alu_res = 32'h30;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("stall_pc",   M_PC,      32'h0000_3100);
        check("stall_ins",  M_ins,     {SW, 26'h0});
        check("stall_alu",  M_alu_res, 32'h30);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        en    = 1'b1;
        check("fl0_ins",    M_ins,     32'h0);
        check("fl0_pc",     M_PC,      32'h0000_3104);
        check("fl0_alu",    M_alu_res, 32'h0);
        issue(32'h3108, LW, 32'h30, 32'h0);
        check("stall_nowr", mem_rdata, 32'h0);

        // flush with en=1: the store in M commits, the flushed store does not
        issue(32'h3200, SW, 32'h34, 32'h0000_00AB);
        flush = 1'b1;
        issue(32'h3204, SW, 32'h38, 32'h0000_00CD);
        flush = 1'b0;
        check("fl1_ins",    M_ins,     32'h0);
        check("fl1_pc",     M_PC,      32'h0000_3204);
        check("fl1_dat",    mem_rdata, 32'h0);
        issue(32'h3208, LW, 32'h38, 32'h0);
        check("fl1_nowr",   mem_rdata, 32'h0);
        issue(32'h320C, LW, 32'h34, 32'h0);
        check("fl1_prev",   mem_rdata, 32'h0000_00AB);

        // async reset mid-cycle with a store in M: immediate clear, no write
        issue(32'h3300, SW, 32'h40, 32'h0000_0077);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pc",    M_PC,      32'h0000_3000);
        check("arst_ins",   M_ins,     32'h0);
        check("arst_alu",   M_alu_res, 32'h0);
        check("arst_dat",   mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(32'h3304, LW, 32'h40, 32'h0);
        check("arst_nowr",  mem_rdata, 32'h0);
        issue(32'h3308, LW, 32'h10, 32'h0);
        check("arst_clr10", mem_rdata, 32'h0);
        issue(32'h330C, LW, 32'h20, 32'h0);
        check("arst_clr20", mem_rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
